// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the RV32 core's M-extension unit.
//   XLEN        : operand/result width (only 32 is supported)
//   MDU_*       : funct3 encodings of the RV32M instructions
//   mdu_state_t : sequencing states of the iterative multiply/divide unit
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational final-step correction of the multiply/divide unit.
// Turns the unsigned magnitude result left in the accumulator into the
// architectural RV32M result: sign restoration, divide-by-zero and the
// signed-overflow case (most-negative / -1).
//   funct3 : latched RV32M operation
//   acc    : accumulator; product {hi,lo} or {remainder,quotient}
//   neg_a  : op_a was negative (signed interpretation only)
//   neg_b  : op_b was negative (signed interpretation only)
//   a_mag  : magnitude of op_a
//   b_mag  : magnitude of op_b
//   result : final 32-bit result
module mdu_sign_fix
   import rv32_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [2*XLEN-1:0] acc,
   input  logic              neg_a,
   input  logic              neg_b,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [XLEN-1:0]   b_mag,
   output logic [XLEN-1:0]   result
);

   logic              neg_res_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   a_orig_s;
   logic              b_zero_s;
   logic              ovf_s;

   // Sign correction and special-case selection of the final result
   always_comb begin
      neg_res_s = neg_a ^ neg_b;
      prod_s    = neg_res_s ? (~acc + 64'd1) : acc;
      quo_s     = neg_res_s ? (~acc[31:0] + 32'd1) : acc[31:0];
      // Remainder follows the dividend's sign
      rem_s     = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
      // Original op_a, needed when the divisor is zero
      a_orig_s  = neg_a ? (~a_mag + 32'd1) : a_mag;
      b_zero_s  = (b_mag == 32'd0);
      // Sign flags are only ever set for signed ops, so this is DIV/REM -2^31 / -1
      ovf_s     = neg_a & neg_b & (a_mag == 32'h8000_0000) & (b_mag == 32'd1);

      case (funct3)
         MDU_MUL:                        result = prod_s[31:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod_s[63:32];
         MDU_DIV, MDU_DIVU: begin
            if (b_zero_s) begin
               result = 32'hFFFF_FFFF;
            end else if (ovf_s) begin
               result = 32'h8000_0000;
            end else begin
               result = quo_s;
            end
         end
         MDU_REM, MDU_REMU: begin
            if (b_zero_s) begin
               result = a_orig_s;
            end else if (ovf_s) begin
               result = 32'h0000_0000;
            end else begin
               result = rem_s;
            end
         end
         default:                        result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/rv32_mdu.sv
// rv32_mdu: iterative RV32M multiply/divide unit for the execute stage.
// Fixed latency: accept in IDLE, 32 iterations in CALC, sign/special-case
// correction in FIX, one-cycle result presentation in DONE.
//   clk, reset     : clock, asynchronous active-high reset
//   start, kill    : request a new op (IDLE only) / abort an op in flight
//   funct3         : RV32M operation
//   op_a, op_b     : rs1/rs2 values
//   rd_in          : destination register index
//   busy           : op in progress (CALC, FIX, DONE)
//   done           : one-cycle result-valid pulse
//   result         : result, held until the next done
//   we_out, rd_out : register-file write enable and destination index
module rv32_mdu
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            we_out,
   output logic [4:0]      rd_out
);

   mdu_state_t        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic [XLEN-1:0]   a_mag_q, a_mag_d;
   logic [XLEN-1:0]   b_mag_q, b_mag_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sgn_a_s, sgn_b_s;
   logic [XLEN-1:0]   a_mag_s, b_mag_s;
   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_next_s;
   logic [XLEN:0]     div_trial_s, div_diff_s;
   logic [2*XLEN-1:0] div_next_s;
   logic [XLEN-1:0]   fix_result_s;

   mdu_sign_fix u_sign_fix (
      .funct3 (f3_q),
      .acc    (acc_q),
      .neg_a  (neg_a_q),
      .neg_b  (neg_b_q),
      .a_mag  (a_mag_q),
      .b_mag  (b_mag_q),
      .result (fix_result_s)
   );

   // Operand sign decode and one shift-add / restoring-divide iteration
   always_comb begin
      sgn_a_s = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
                (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
      sgn_b_s = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
      a_mag_s = (sgn_a_s && op_a[31]) ? (~op_a + 32'd1) : op_a;
      b_mag_s = (sgn_b_s && op_b[31]) ? (~op_b + 32'd1) : op_b;

      // Multiply: acc = {partial_hi, remaining multiplier bits}; add then shift right
      mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
      mul_next_s = {mul_sum_s, acc_q[31:1]};

      // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
      // The trial never exceeds 2*divisor-1, so a kept difference fits in 32 bits.
      div_trial_s = acc_q[63:31];
      div_diff_s  = div_trial_s - {1'b0, b_mag_q};
      div_next_s  = div_diff_s[32] ? {div_trial_s[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff_s[31:0],  acc_q[30:0], 1'b1};
   end

   // Next-state and next-output computation for the sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      acc_d    = acc_q;
      result_d = result_q;
      done_d   = 1'b0;
      we_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (kill) begin
               state_d = IDLE;
            end else if (start) begin
               state_d = CALC;
               cnt_d   = 5'd0;
               f3_d    = funct3;
               rd_d    = rd_in;
               neg_a_d = sgn_a_s & op_a[31];
               neg_b_d = sgn_b_s & op_b[31];
               a_mag_d = a_mag_s;
               b_mag_d = b_mag_s;
               // Divide iterates over the dividend, multiply over the multiplier
               acc_d   = funct3[2] ? {32'd0, a_mag_s} : {32'd0, b_mag_s};
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               acc_d = f3_q[2] ? div_next_s : mul_next_s;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_d = FIX;
               end else begin
                  state_d = CALC;
               end
            end
         end
         FIX: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               state_d  = DONE;
               result_d = fix_result_s;
               done_d   = 1'b1;
               we_d     = (rd_q != 5'd0);
            end
         end
         DONE: begin
            // kill is ignored here: the result has already committed
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, datapath and registered-output flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         f3_q     <= 3'd0;
         rd_q     <= 5'd0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         a_mag_q  <= 32'd0;
         b_mag_q  <= 32'd0;
         acc_q    <= 64'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         we_q     <= we_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign we_out = we_q;
   assign result = result_q;
   assign rd_out = rd_q;

endmodule

// File: tb/tb_rv32_mdu.sv
// tb_rv32_mdu: scoreboard bench for rv32_mdu. Stimulus pushes hand-computed
// expected results into a queue; a monitor pops and compares on every done.
module tb_rv32_mdu;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, kill;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done, we_out;
   logic [31:0] result;
   logic [4:0]  rd_out;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   rv32_mdu dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .we_out (we_out),
      .rd_out (rd_out)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: result=%h rd_out=%0d with nothing outstanding", result, rd_out);
         end else begin
            e = exp_q.pop_front();
            check32("result", result, e.res);
            check32("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            check32("we_out", {31'd0, we_out}, {31'd0, e.we});
         end
      end
   end

   // Issue one op, optionally poke a second start mid-flight, and check latency
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input bit inject);
      exp_t e;
      int   k;
      bit   seen;
      @(negedge clk);
      funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      e.res = exp_res; e.rd = rd; e.we = (rd != 5'd0);
      exp_q.push_back(e);
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (k == 1) check32("busy_after_start", {31'd0, busy}, 32'd1);
         if (inject && k == 5) begin
            start = 1'b1; funct3 = MDU_MUL; op_a = 32'd99; op_b = 32'd3; rd_in = 5'd31;
         end
         if (done === 1'b1) seen = 1'b1;
      end
      start = 1'b0;
      check32("done_latency", k, 32'd34);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; kill = 1'b0;
      funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
      repeat (2) @(negedge clk);
      check32("rst_busy",   {31'd0, busy},   32'd0);
      check32("rst_done",   {31'd0, done},   32'd0);
      check32("rst_we",     {31'd0, we_out}, 32'd0);
      check32("rst_result", result,          32'd0);
      check32("rst_rd",     {27'd0, rd_out}, 32'd0);
      reset = 1'b0;

      run_op(MDU_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         1'b0);
      run_op(MDU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  1'b0);
      run_op(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  1'b0);
      run_op(MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  1'b0);
      run_op(MDU_DIV,    32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  1'b0);
      run_op(MDU_REM,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  1'b0);
      run_op(MDU_DIV,    32'd7,          32'hFFFF_FFFE,  5'd14, 32'hFFFF_FFFD,  1'b0);
      run_op(MDU_REM,    32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          1'b0);
      run_op(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1'b0);
      run_op(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h0000_0000,  1'b0);
      run_op(MDU_DIVU,   32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  1'b0);
      run_op(MDU_REMU,   32'd5,          32'd0,          5'd10, 32'd5,          1'b0);
      run_op(MDU_MULHU,  32'h8000_0000,  32'd4,          5'd0,  32'd2,          1'b0);
      run_op(MDU_DIVU,   32'd100,        32'd7,          5'd11, 32'd14,         1'b1);

      // start together with kill in IDLE is not accepted
      @(negedge clk);
      funct3 = MDU_MUL; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd1; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check32("start_kill_busy", {31'd0, busy}, 32'd0);

      // kill in cycle 10 of CALC: no done, result untouched
      @(negedge clk);
      funct3 = MDU_DIVU; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check32("kill_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      check32("kill_result_held", result, 32'd14);
      check32("kill_we", {31'd0, we_out}, 32'd0);
      run_op(MDU_MUL, 32'd3, 32'd5, 5'd12, 32'd15, 1'b0);

      // asynchronous reset mid-CALC
      @(negedge clk);
      funct3 = MDU_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'd9; rd_in = 5'd21; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      check32("arst_busy",   {31'd0, busy},   32'd0);
      check32("arst_done",   {31'd0, done},   32'd0);
      check32("arst_we",     {31'd0, we_out}, 32'd0);
      check32("arst_result", result,          32'd0);
      check32("arst_rd",     {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(MDU_REMU, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);

      repeat (5) @(negedge clk);
      check32("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
